// File: rtl/lz77_pkg.sv
// ----------------------------------------------------------------------------
// lz77_pkg
// Shared constants and types for the LZ77 decoder and the encoder bench.
//   SEARCH_DEPTH : history window depth in bytes (legal offsets 0..SEARCH_DEPTH-1)
//   OFF_W        : offset field width
//   LEN_W        : match_len field width (max copy length 2**LEN_W-1)
//   TERM_CHAR    : literal that ends the stream ('$')
//   state_t      : decoder FSM states
//   token_t      : packed {offset, match_len, char_nxt} token
// ----------------------------------------------------------------------------
package lz77_pkg;

   localparam int         SEARCH_DEPTH = 9;
   localparam int         OFF_W        = 4;
   localparam int         LEN_W        = 3;
   localparam logic [7:0] TERM_CHAR    = 8'h24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      LIT  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [OFF_W-1:0] offset;
      logic [LEN_W-1:0] match_len;
      logic [7:0]       char_nxt;
   } token_t;

endpackage

// File: rtl/lz77_hist_buf.sv
// ----------------------------------------------------------------------------
// lz77_hist_buf
// SEARCH_DEPTH x 8 shift-register history window. Entry 0 is the most
// recently emitted byte. Reads with an index past the window return 8'h00.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  synchronous active-low clear (all entries to 8'h00)
//   shift_en in  shift din into entry 0, older entries move up by one
//   din      in  byte to insert
//   rd_idx   in  read index (0 = newest)
//   rd_data  out combinational read data
// ----------------------------------------------------------------------------
module lz77_hist_buf
   import lz77_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic [7:0]       din,
   input  logic [OFF_W-1:0] rd_idx,
   output logic [7:0]       rd_data
);

   logic [7:0] r_hist [SEARCH_DEPTH];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < SEARCH_DEPTH; i++) r_hist[i] <= 8'h00;
      end else if (shift_en) begin
         r_hist[0] <= din;
         for (int i = 1; i < SEARCH_DEPTH; i++) r_hist[i] <= r_hist[i-1];
      end
   end

   // Offsets wider than the window are not trapped here; they read as zero.
   always_comb begin
      rd_data = 8'h00;
      if (int'(rd_idx) < SEARCH_DEPTH) rd_data = r_hist[rd_idx];
   end

endmodule

// File: rtl/lz77_decoder.sv
// ----------------------------------------------------------------------------
// lz77_decoder
// Expands (offset, match_len, char_nxt) tokens into a byte stream: match_len
// bytes copied from the history window followed by the literal char_nxt.
// One byte per cycle under valid/ready; stops (finish sticky) after emitting
// TERM_CHAR.
// Optional feature macro: LZ77_DEC_ERRCHK_EN
//   defined   : tokens with offset > SEARCH_DEPTH-1 are accepted and dropped,
//               err pulses for one cycle.
//   undefined : err tied low, out-of-window offsets copy 8'h00.
// Ports:
//   clk, reset (sync, active-low)
//   tok_valid/tok_ready, offset, match_len, char_nxt : token input
//   out_valid/out_ready, out_char                    : byte output
//   finish : stream complete, sticky until reset
//   err    : illegal-token pulse
// ----------------------------------------------------------------------------
module lz77_decoder
   import lz77_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             tok_valid,
   output logic             tok_ready,
   input  logic [OFF_W-1:0] offset,
   input  logic [LEN_W-1:0] match_len,
   input  logic [7:0]       char_nxt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             finish,
   output logic             err
);

   state_t           r_state;
   logic [OFF_W-1:0] r_off;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [7:0]       r_chr;
   logic             r_tok_ready;
   logic             r_out_valid;
   logic             r_finish;

   logic             w_accept;
   logic             w_out_hs;
   logic             w_bad_off;
   logic [7:0]       w_rd_data;
   logic [7:0]       w_out_char;

   assign w_accept = tok_valid && r_tok_ready;
   assign w_out_hs = r_out_valid && out_ready;

`ifdef LZ77_DEC_ERRCHK_EN
   logic r_err;
   assign w_bad_off = (int'(offset) > SEARCH_DEPTH - 1);
   assign err       = r_err;
`else
   assign w_bad_off = 1'b0;
   assign err       = 1'b0;
`endif

   // The read index stays fixed for the whole copy; since the window shifts
   // by one per emitted byte, offset < match_len naturally replays a run.
   lz77_hist_buf u_hist (
      .clk      (clk),
      .reset    (reset),
      .shift_en (w_out_hs),
      .din      (w_out_char),
      .rd_idx   (r_off),
      .rd_data  (w_rd_data)
   );

   always_comb begin
      w_out_char = 8'h00;
      if (r_state == COPY)     w_out_char = w_rd_data;
      else if (r_state == LIT) w_out_char = r_chr;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_off       <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_chr       <= 8'h00;
         r_tok_ready <= 1'b0;
         r_out_valid <= 1'b0;
         r_finish    <= 1'b0;
`ifdef LZ77_DEC_ERRCHK_EN
         r_err       <= 1'b0;
`endif
      end else begin
`ifdef LZ77_DEC_ERRCHK_EN
         r_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               // tok_ready rises one cycle after reset release.
               r_tok_ready <= 1'b1;
               if (w_accept) begin
                  if (w_bad_off) begin
`ifdef LZ77_DEC_ERRCHK_EN
                     r_err <= 1'b1;
`endif
                  end else begin
                     r_off       <= offset;
                     r_len       <= match_len;
                     r_chr       <= char_nxt;
                     r_cnt       <= '0;
                     r_state     <= (match_len != '0) ? COPY : LIT;
                     r_tok_ready <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            COPY: begin
               if (w_out_hs) begin
                  r_cnt <= r_cnt + LEN_W'(1);
                  if (r_cnt == r_len - LEN_W'(1)) r_state <= LIT;
               end
            end
            LIT: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  if (r_chr == TERM_CHAR) begin
                     r_state  <= DONE;
                     r_finish <= 1'b1;
                  end else begin
                     r_state     <= IDLE;
                     r_tok_ready <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_tok_ready <= 1'b0;
               r_out_valid <= 1'b0;
               r_finish    <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tok_ready = r_tok_ready;
   assign out_valid = r_out_valid;
   assign out_char  = w_out_char;
   assign finish    = r_finish;

endmodule

// File: tb/tb_lz77_decoder.sv
// ----------------------------------------------------------------------------
// tb_lz77_decoder
// Directed and randomized token streams against a byte-level reference model
// of LZ77 expansion (history kept as a plain queue of emitted bytes).
// ----------------------------------------------------------------------------
module tb_lz77_decoder;
   import lz77_pkg::*;

   logic             clk       = 1'b0;
   logic             reset     = 1'b0;
   logic             tok_valid = 1'b0;
   logic             tok_ready;
   logic [OFF_W-1:0] offset    = '0;
   logic [LEN_W-1:0] match_len = '0;
   logic [7:0]       char_nxt  = 8'h00;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [7:0]       out_char;
   logic             finish;
   logic             err;

   int n_vec = 0;
   int n_bad = 0;

   byte unsigned exp_q[$];
   byte unsigned mdl_hist[$];
   bit           bp_mode   = 1'b0;
   int           stall_cnt = 0;

   always #5 clk = ~clk;

   lz77_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .tok_valid (tok_valid),
      .tok_ready (tok_ready),
      .offset    (offset),
      .match_len (match_len),
      .char_nxt  (char_nxt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .finish    (finish),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference expansion: a copy byte at distance off+1 back in the emitted
   // stream, zero if outside the window or before the stream start.
   task automatic model_token(input int off, input int len, input byte unsigned ch);
`ifdef LZ77_DEC_ERRCHK_EN
      if (off > SEARCH_DEPTH - 1) return;
`endif
      for (int i = 0; i < len; i++) begin
         byte unsigned b;
         if (off >= SEARCH_DEPTH || off >= mdl_hist.size()) b = 8'h00;
         else b = mdl_hist[mdl_hist.size() - 1 - off];
         mdl_hist.push_back(b);
         exp_q.push_back(b);
      end
      mdl_hist.push_back(ch);
      exp_q.push_back(ch);
   endtask

   task automatic send_token(input int off, input int len, input byte unsigned ch);
      int     w;
      token_t t;
      w = 0;
      @(posedge clk); #1;
      while (!tok_ready && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      if (!tok_ready) begin
         check("tok_ready_timeout", {31'd0, tok_ready}, 32'd1);
         return;
      end
      t.offset    = off[OFF_W-1:0];
      t.match_len = len[LEN_W-1:0];
      t.char_nxt  = ch;
      offset      = t.offset;
      match_len   = t.match_len;
      char_nxt    = t.char_nxt;
      tok_valid   = 1'b1;
      @(posedge clk); #1;
      tok_valid = 1'b0;
      model_token(off, len, ch);
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset     = 1'b0;
      tok_valid = 1'b0;
      exp_q.delete();
      mdl_hist.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Output-side ready: forced stalls first, else random or always-ready.
   always @(posedge clk) begin
      #1;
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else if (bp_mode) begin
         out_ready = 1'($urandom_range(0, 1));
      end else begin
         out_ready = 1'b1;
      end
   end

   // Byte monitor: every handshake is checked in order; a stalled byte must
   // be unchanged and still valid on the following cycle.
   logic [7:0] held_char;
   bit         held = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_char", {24'd0, out_char}, {24'd0, held_char});
            held = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_byte", {24'd0, out_char}, 32'hFFFF_FFFF);
            else check("out_char", {24'd0, out_char}, {24'd0, exp_q.pop_front()});
         end else if (out_valid) begin
            held      = 1'b1;
            held_char = out_char;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tok_ready", {31'd0, tok_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_char", {24'd0, out_char}, 32'd0);
      check("rst_finish", {31'd0, finish}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      reset = 1'b1;

      // Literal-only stream ending in '$'
      send_token(0, 0, "A");
      send_token(0, 0, "B");
      send_token(0, 0, "$");
      wait_drain();
      check("lit_finish", {31'd0, finish}, 32'd1);
      check("lit_tok_ready_done", {31'd0, tok_ready}, 32'd0);
      check("lit_out_valid_done", {31'd0, out_valid}, 32'd0);
      offset    = '0;
      match_len = '0;
      char_nxt  = "Q";
      tok_valid = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         check("done_ignore_valid", {31'd0, out_valid}, 32'd0);
         check("done_ignore_ready", {31'd0, tok_ready}, 32'd0);
      end
      tok_valid = 1'b0;
      check("done_finish_sticky", {31'd0, finish}, 32'd1);

      // Copy with a forced 3-cycle stall during the copy
      do_reset();
      send_token(0, 0, "a");
      send_token(0, 0, "b");
      send_token(0, 0, "c");
      send_token(2, 3, "d");
      stall_cnt = 3;
      wait_drain();

      // Overlapping run
      send_token(0, 0, "x");
      send_token(0, 7, "y");
      wait_drain();

      // Reset in the middle of a copy
      send_token(0, 0, "k");
      send_token(0, 6, "m");
      @(posedge clk); #1;
      check("midcopy_valid_before", {31'd0, out_valid}, 32'd1);
      reset = 1'b0;
      exp_q.delete();
      mdl_hist.delete();
      @(posedge clk); #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_finish", {31'd0, finish}, 32'd0);
      check("midrst_tok_ready", {31'd0, tok_ready}, 32'd0);
      check("midrst_out_char", {24'd0, out_char}, 32'd0);
      reset = 1'b1;
      send_token(0, 0, "Z");
      // Reads one slot past 'Z': zero only if the window was cleared.
      send_token(1, 2, "w");
      wait_drain();

      // Out-of-window offset
`ifdef LZ77_DEC_ERRCHK_EN
      send_token(12, 1, "q");
      check("err_pulse", {31'd0, err}, 32'd1);
      check("err_no_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("err_one_cycle", {31'd0, err}, 32'd0);
      check("err_tok_ready", {31'd0, tok_ready}, 32'd1);
`else
      send_token(12, 1, "q");
      check("err_tied_low", {31'd0, err}, 32'd0);
`endif
      send_token(0, 0, "r");
      wait_drain();

      // Randomized stream with random backpressure
      do_reset();
      bp_mode = 1'b1;
      for (int n = 0; n < 60; n++) begin
         byte unsigned ch;
         do ch = 8'($urandom_range(0, 255)); while (ch == TERM_CHAR);
         send_token(int'($urandom_range(0, SEARCH_DEPTH - 1)), int'($urandom_range(0, 7)), ch);
      end
      send_token(int'($urandom_range(0, SEARCH_DEPTH - 1)), int'($urandom_range(0, 7)), TERM_CHAR);
      wait_drain();
      bp_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rand_finish", {31'd0, finish}, 32'd1);
      check("rand_tok_ready", {31'd0, tok_ready}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
